exit_monitor: RTL and testbench

Parametrised simulation-completion and pipeline-occupancy monitor for the RISC-V core bench. It counts valid instructions per pipeline stage and detects the pass/fail PCs at fetch, with an optional idle-retire watchdog. It reports a sticky, registered completion status that the top level polls to end the run. It replaces the ad-hoc per-stage counters and PC compares in the bench top, and it is synthesizable so it can also sit beside the core on FPGA.

---
 rtl/exit_monitor.sv | 132 +++++++++++++
 tb/tb_exit_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exit_monitor.sv
// Simulation-completion and pipeline-occupancy monitor: per-stage valid counters,
// pass/fail PC detection at fetch, optional idle-retire watchdog (EXIT_MONITOR_WATCHDOG_EN).
module exit_monitor #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [STAGES-1:0]       stage_v,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [XLEN-1:0]         pass_pc,
  input  logic [XLEN-1:0]         fail_pc,
  input  logic [CNT_W-1:0]        wd_limit,
  input  logic                    clear,
  output logic [STAGES*CNT_W-1:0] cnt_flat,
  output logic [CNT_W-1:0]        cycles,
  output logic [1:0]              state,
  output logic                    done,
  output logic [XLEN-1:0]         done_pc
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_done;
  logic [XLEN-1:0]  r_done_pc;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_cnt [STAGES];

  logic w_run;
  logic w_hit_fail;
  logic w_hit_pass;
  logic w_timeout;

  assign w_run = (r_state == ST_RUN);

  // Ternary keeps an unqualified (possibly X) pc_i from reaching the compare result.
  assign w_hit_fail = stage_v[0] ? (pc_i == fail_pc) : 1'b0;
  assign w_hit_pass = stage_v[0] ? (pc_i == pass_pc) : 1'b0;

`ifdef EXIT_MONITOR_WATCHDOG_EN
  logic [CNT_W-1:0] r_idle;
  logic [CNT_W-1:0] w_wd_last;

  assign w_wd_last = wd_limit - CNT_ONE;
  assign w_timeout = (wd_limit != '0) && !stage_v[STAGES-1] && (r_idle == w_wd_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idle <= '0;
    end else if (clear) begin
      r_idle <= '0;
    end else if (w_run) begin
      if (stage_v[STAGES-1]) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + CNT_ONE;
      end
    end
  end
`else
  logic w_unused_wd;

  assign w_unused_wd = ^wd_limit;
  assign w_timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycles <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_cnt[k] <= '0;
      end
    end else if (clear) begin
      r_cycles <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_cnt[k] <= '0;
      end
    end else if (w_run) begin
      r_cycles <= r_cycles + CNT_ONE;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (stage_v[k]) begin
          r_cnt[k] <= r_cnt[k] + CNT_ONE;
        end
      end
    end
  end

  // Terminal states are sticky; FAIL outranks PASS so pass_pc==fail_pc reports FAIL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_done    <= 1'b0;
      r_done_pc <= '0;
    end else if (w_run) begin
      if (w_hit_fail) begin
        r_state   <= ST_FAIL;
        r_done    <= 1'b1;
        r_done_pc <= pc_i;
      end else if (w_hit_pass) begin
        r_state   <= ST_PASS;
        r_done    <= 1'b1;
        r_done_pc <= pc_i;
      end else if (w_timeout) begin
        r_state   <= ST_TIMEOUT;
        r_done    <= 1'b1;
        r_done_pc <= '0;
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      cnt_flat[k*CNT_W +: CNT_W] = r_cnt[k];
    end
  end

  assign cycles  = r_cycles;
  assign state   = r_state;
  assign done    = r_done;
  assign done_pc = r_done_pc;

endmodule

// File: tb/tb_exit_monitor.sv
// Directed self-checking bench for exit_monitor; a second CNT_W=4 instance covers counter wrap.
module tb_exit_monitor;

  logic         clk;
  logic         reset;
  logic [3:0]   stage_v;
  logic [31:0]  pc_i;
  logic [31:0]  pass_pc;
  logic [31:0]  fail_pc;
  logic [31:0]  wd_limit;
  logic [3:0]   wd_limit4;
  logic         clear;

  logic [127:0] cnt_flat;
  logic [31:0]  cycles;
  logic [1:0]   state;
  logic         done;
  logic [31:0]  done_pc;

  logic [15:0]  cnt_flat4;
  logic [3:0]   cycles4;
  logic [1:0]   state4;
  logic         done4;
  logic [31:0]  done_pc4;

  int checks;
  int failures;

  exit_monitor #(.STAGES(4), .XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .stage_v(stage_v), .pc_i(pc_i),
    .pass_pc(pass_pc), .fail_pc(fail_pc), .wd_limit(wd_limit), .clear(clear),
    .cnt_flat(cnt_flat), .cycles(cycles), .state(state), .done(done), .done_pc(done_pc)
  );

  exit_monitor #(.STAGES(4), .XLEN(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .stage_v(stage_v), .pc_i(pc_i),
    .pass_pc(pass_pc), .fail_pc(fail_pc), .wd_limit(wd_limit4), .clear(clear),
    .cnt_flat(cnt_flat4), .cycles(cycles4), .state(state4), .done(done4), .done_pc(done_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cnt(input int k);
    return cnt_flat[k*32 +: 32];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves reset asserted so the caller releases it together with its first stimulus.
  task automatic hold_reset(input int n);
    reset   = 1'b0;
    stage_v = 4'b0000;
    clear   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset;
    pass_pc = 32'h0000_0040;
    fail_pc = 32'h0000_0080;
    wd_limit = '0;
    reset   = 1'b0;
    clear   = 1'b0;
    stage_v = 4'b1111;
    pc_i    = pass_pc;
    repeat (3) tick();
    checks++; if (cnt_flat !== 128'd0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", cnt_flat); end
    checks++; if (cycles !== 32'd0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", state); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (done_pc !== 32'd0) begin failures++; $display("FAIL reset_done_pc got=%0h exp=0", done_pc); end
  endtask

  task automatic test_pass;
    pass_pc = 32'h8000_0044;
    fail_pc = 32'h8000_0100;
    hold_reset(2);
    reset   = 1'b1;
    stage_v = 4'b0001;
    for (int n = 0; n < 18; n++) begin
      pc_i = 32'h8000_0000 + 32'(4 * n);
      tick();
      if (n < 17) begin
        checks++; if (state !== 2'b00) begin failures++; $display("FAIL pass_early_state n=%0d got=%b exp=00", n, state); end
      end
    end
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL pass_state got=%b exp=01", state); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL pass_done got=%b exp=1", done); end
    checks++; if (done_pc !== 32'h8000_0044) begin failures++; $display("FAIL pass_done_pc got=%0h exp=80000044", done_pc); end
    checks++; if (cnt(0) !== 32'd18) begin failures++; $display("FAIL pass_cnt0 got=%0d exp=18", cnt(0)); end
    checks++; if (cycles !== 32'd18) begin failures++; $display("FAIL pass_cycles got=%0d exp=18", cycles); end
    // Terminal state must ignore further activity, including a fail PC.
    stage_v = 4'b1111;
    pc_i    = fail_pc;
    repeat (10) tick();
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL sticky_state got=%b exp=01", state); end
    checks++; if (done_pc !== 32'h8000_0044) begin failures++; $display("FAIL sticky_done_pc got=%0h exp=80000044", done_pc); end
    checks++; if (cnt(0) !== 32'd18) begin failures++; $display("FAIL sticky_cnt0 got=%0d exp=18", cnt(0)); end
    checks++; if (cnt(3) !== 32'd0) begin failures++; $display("FAIL sticky_cnt3 got=%0d exp=0", cnt(3)); end
    checks++; if (cycles !== 32'd18) begin failures++; $display("FAIL sticky_cycles got=%0d exp=18", cycles); end
    // Mid-run reset from a terminal state.
    reset = 1'b0;
    tick();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL midreset_state got=%b exp=00", state); end
    checks++; if (done_pc !== 32'd0) begin failures++; $display("FAIL midreset_done_pc got=%0h exp=0", done_pc); end
    checks++; if (cycles !== 32'd0) begin failures++; $display("FAIL midreset_cycles got=%0d exp=0", cycles); end
  endtask

  task automatic test_fail_priority;
    pass_pc = 32'h0000_0100;
    fail_pc = 32'h0000_0100;
    hold_reset(1);
    reset   = 1'b1;
    stage_v = 4'b0000;
    pc_i    = 32'h0000_0100;
    repeat (2) tick();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL unqualified_pc_state got=%b exp=00", state); end
    stage_v = 4'b0001;
    tick();
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL eq_state got=%b exp=10", state); end
    checks++; if (done_pc !== 32'h0000_0100) begin failures++; $display("FAIL eq_done_pc got=%0h exp=100", done_pc); end
    checks++; if (cnt(0) !== 32'd1) begin failures++; $display("FAIL eq_cnt0 got=%0d exp=1", cnt(0)); end
    checks++; if (cycles !== 32'd3) begin failures++; $display("FAIL eq_cycles got=%0d exp=3", cycles); end
  endtask

  task automatic test_clear;
    pass_pc = 32'h0000_0200;
    fail_pc = 32'h0000_0300;
    hold_reset(1);
    reset   = 1'b1;
    stage_v = 4'b1111;
    pc_i    = 32'h0000_0000;
    repeat (3) tick();
    checks++; if (cnt_flat !== {32'd3, 32'd3, 32'd3, 32'd3}) begin failures++; $display("FAIL preclear_cnt got=%0h exp=all 3", cnt_flat); end
    clear = 1'b1;
    tick();
    checks++; if (cnt_flat !== 128'd0) begin failures++; $display("FAIL clear_cnt got=%0h exp=0", cnt_flat); end
    checks++; if (cycles !== 32'd0) begin failures++; $display("FAIL clear_cycles got=%0d exp=0", cycles); end
    clear   = 1'b0;
    stage_v = 4'b0001;
    tick();
    checks++; if (cnt(0) !== 32'd1) begin failures++; $display("FAIL postclear_cnt0 got=%0d exp=1", cnt(0)); end
    checks++; if (cnt(1) !== 32'd0) begin failures++; $display("FAIL postclear_cnt1 got=%0d exp=0", cnt(1)); end
    checks++; if (cycles !== 32'd1) begin failures++; $display("FAIL postclear_cycles got=%0d exp=1", cycles); end
    pc_i = pass_pc;
    tick();
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL clear_pass_state got=%b exp=01", state); end
    clear = 1'b1;
    tick();
    checks++; if (cycles !== 32'd0) begin failures++; $display("FAIL term_clear_cycles got=%0d exp=0", cycles); end
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL term_clear_state got=%b exp=01", state); end
    checks++; if (done_pc !== 32'h0000_0200) begin failures++; $display("FAIL term_clear_done_pc got=%0h exp=200", done_pc); end
    clear = 1'b0;
  endtask

  task automatic test_wrap;
    pass_pc = 32'h0000_0010;
    fail_pc = 32'h0000_0020;
    hold_reset(1);
    reset   = 1'b1;
    stage_v = 4'b0010;
    pc_i    = pass_pc;
    repeat (17) tick();
    checks++; if (cnt_flat4[7:4] !== 4'd1) begin failures++; $display("FAIL wrap_cnt1 got=%0d exp=1", cnt_flat4[7:4]); end
    checks++; if (cycles4 !== 4'd1) begin failures++; $display("FAIL wrap_cycles got=%0d exp=1", cycles4); end
    checks++; if (cnt(1) !== 32'd17) begin failures++; $display("FAIL wide_cnt1 got=%0d exp=17", cnt(1)); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL wrap_state got=%b exp=00", state); end
  endtask

`ifdef EXIT_MONITOR_WATCHDOG_EN
  task automatic test_watchdog;
    pass_pc  = 32'h0000_0400;
    fail_pc  = 32'h0000_0500;
    wd_limit = 32'd5;
    hold_reset(1);
    reset   = 1'b1;
    stage_v = 4'b0000;
    pc_i    = 32'h0;
    repeat (4) tick();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL wd_early_state got=%b exp=00", state); end
    tick();
    checks++; if (state !== 2'b11) begin failures++; $display("FAIL wd_state got=%b exp=11", state); end
    checks++; if (done_pc !== 32'd0) begin failures++; $display("FAIL wd_done_pc got=%0h exp=0", done_pc); end
    checks++; if (cycles !== 32'd5) begin failures++; $display("FAIL wd_cycles got=%0d exp=5", cycles); end
    hold_reset(1);
    reset = 1'b1;
    repeat (3) tick();
    stage_v = 4'b1000;
    tick();
    stage_v = 4'b0000;
    tick();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL wd_retire_state got=%b exp=00", state); end
    repeat (4) tick();
    checks++; if (state !== 2'b11) begin failures++; $display("FAIL wd_late_state got=%b exp=11", state); end
    wd_limit = '0;
  endtask
`else
  task automatic test_no_watchdog;
    pass_pc  = 32'h0000_0400;
    fail_pc  = 32'h0000_0500;
    wd_limit = 32'd1;
    hold_reset(1);
    reset   = 1'b1;
    stage_v = 4'b0000;
    pc_i    = 32'h0;
    repeat (100) tick();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL nowd_state got=%b exp=00", state); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL nowd_done got=%b exp=0", done); end
    checks++; if (cycles !== 32'd100) begin failures++; $display("FAIL nowd_cycles got=%0d exp=100", cycles); end
    wd_limit = '0;
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    stage_v   = 4'b0000;
    pc_i      = '0;
    pass_pc   = '0;
    fail_pc   = '0;
    wd_limit  = '0;
    wd_limit4 = '0;
    clear     = 1'b0;
    test_reset();
    test_pass();
    test_fail_priority();
    test_clear();
    test_wrap();
`ifdef EXIT_MONITOR_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
